// File: rtl/debug_ctrlr.sv
// debug_ctrlr: UART-debugger controller between the serial command decoder
// and the MCU debug port. Decodes commands into MCU strobes, tracks the
// MCU paused state, owns a breakpoint table, and runs N-step execution and
// a timed MCU reset pulse.
// Optional feature: define DBG_HIT_CNT_EN to add per-slot saturating hit
// counters and the o_bp_hit_cnt output.
module debug_ctrlr #(
  parameter int ADDR_W     = 32,
  parameter int NUM_BP     = 8,
  parameter int STEP_W     = 8,
  parameter int PC_OFFSET  = 4,
  parameter int RST_CYCLES = 4,
  localparam int BP_IW     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_cmd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_in_valid,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_mcu_busy,
  output logic              o_pause,
  output logic              o_resume,
  output logic              o_reset,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic              o_reg_rd,
  output logic              o_reg_wr,
  output logic [3:0]        o_mem_be,
  output logic              o_out_valid,
  output logic              o_ctrlr_busy,
  output logic              o_mcu_paused,
  output logic              o_bp_full,
  output logic [BP_IW-1:0]  o_bp_hit_idx,
`ifdef DBG_HIT_CNT_EN
  output logic [15:0]       o_bp_hit_cnt,
`endif
  output logic              o_err
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  // Command codes
  localparam logic [3:0] CMD_NONE     = 4'h0;
  localparam logic [3:0] CMD_PAUSE    = 4'h1;
  localparam logic [3:0] CMD_RESUME   = 4'h2;
  localparam logic [3:0] CMD_STEP     = 4'h3;
  localparam logic [3:0] CMD_RESET    = 4'h4;
  localparam logic [3:0] CMD_STATUS   = 4'h5;
  localparam logic [3:0] CMD_MEM_RD_B = 4'h6;
  localparam logic [3:0] CMD_MEM_RD_W = 4'h7;
  localparam logic [3:0] CMD_REG_RD   = 4'h8;
  localparam logic [3:0] CMD_BP_ADD   = 4'h9;
  localparam logic [3:0] CMD_BP_RM    = 4'hA;
  localparam logic [3:0] CMD_MEM_WR_B = 4'hB;
  localparam logic [3:0] CMD_MEM_WR_W = 4'hC;
  localparam logic [3:0] CMD_REG_WR   = 4'hD;

  // FSM states
  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_WAIT_PAUSE  = 4'd1;
  localparam logic [3:0] S_WAIT_RESUME = 4'd2;
  localparam logic [3:0] S_WAIT_MEM    = 4'd3;
  localparam logic [3:0] S_WAIT_REG    = 4'd4;
  localparam logic [3:0] S_STEP_RUN    = 4'd5;
  localparam logic [3:0] S_STEP_PAUSE  = 4'd6;
  localparam logic [3:0] S_MCU_RST     = 4'd7;
  localparam logic [3:0] S_BREAK_HIT   = 4'd8;

  // Byte enables: word access drives all lanes, byte access one lane.
  function automatic logic [3:0] be_of(input logic [3:0] cmd, input logic [1:0] lo);
    logic [3:0] be;
    case (cmd)
      CMD_MEM_RD_W, CMD_MEM_WR_W: be = 4'b1111;
      CMD_MEM_RD_B, CMD_MEM_WR_B: be = 4'b0001 << lo;
      default:                    be = 4'b0000;
    endcase
    return be;
  endfunction

  // Access strobes packed as {mem_rd, mem_wr, reg_rd, reg_wr}.
  function automatic logic [3:0] acc_of(input logic [3:0] cmd);
    logic [3:0] acc;
    case (cmd)
      CMD_MEM_RD_B, CMD_MEM_RD_W: acc = 4'b1000;
      CMD_MEM_WR_B, CMD_MEM_WR_W: acc = 4'b0100;
      CMD_REG_RD:                 acc = 4'b0010;
      CMD_REG_WR:                 acc = 4'b0001;
      default:                    acc = 4'b0000;
    endcase
    return acc;
  endfunction

  logic [3:0]        r_state;
  logic [3:0]        r_cmd;
  logic [1:0]        r_addr_lo;
  logic              r_paused;
  logic [STEP_W-1:0] r_step_cnt;
  logic [RC_W-1:0]   r_rst_cnt;
  logic              r_fresh;
  logic [BP_IW-1:0]  r_hit_idx;
  logic [ADDR_W-1:0] r_bp_addr [NUM_BP];
  logic [NUM_BP-1:0] r_bp_vld;

  logic [ADDR_W-1:0] w_pc_tgt;
  logic [NUM_BP-1:0] w_pc_match;
  logic [NUM_BP-1:0] w_addr_match;
  logic              w_hit_any;
  logic [BP_IW-1:0]  w_hit_sel;
  logic              w_free_any;
  logic [BP_IW-1:0]  w_free_sel;
  logic              w_dup;
  logic              w_full;
  logic              w_hit;
  logic              w_accept;
  logic              w_add_wr;
  logic              w_rm_wr;
  logic              w_err;
  logic              w_pause;
  logic              w_resume;
  logic              w_reset;
  logic [3:0]        w_acc;
  logic [3:0]        w_be;

  assign w_pc_tgt = i_pc + ADDR_W'(PC_OFFSET);

  // Per-slot comparisons against the PC target and the command operand.
  always_comb begin
    for (int i = 0; i < NUM_BP; i++) begin
      w_pc_match[i]   = r_bp_vld[i] && (r_bp_addr[i] == w_pc_tgt);
      w_addr_match[i] = r_bp_vld[i] && (r_bp_addr[i] == i_addr);
    end
  end

  // Lowest matching slot for hits and lowest free slot for adds.
  always_comb begin
    w_hit_sel  = '0;
    w_free_sel = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      w_hit_sel  = w_pc_match[i] ? BP_IW'(i) : w_hit_sel;
      w_free_sel = !r_bp_vld[i]  ? BP_IW'(i) : w_free_sel;
    end
  end

  assign w_hit_any  = |w_pc_match;
  assign w_free_any = ~&r_bp_vld;
  assign w_full     = &r_bp_vld;
  assign w_dup      = |w_addr_match;

  // A hit pre-empts any command presented in the same IDLE cycle.
  assign w_hit    = (r_state == S_IDLE) && !r_paused && w_hit_any;
  assign w_accept = (r_state == S_IDLE) && i_in_valid && !w_hit;
  assign w_add_wr = w_accept && (i_cmd == CMD_BP_ADD) && !w_dup && w_free_any;
  assign w_rm_wr  = w_accept && (i_cmd == CMD_BP_RM);

  // Rejected commands: step while running, add into a full table,
  // remove with no match, and unassigned codes.
  always_comb begin
    w_err = 1'b0;
    if (w_accept) begin
      case (i_cmd)
        CMD_STEP:   w_err = !r_paused;
        CMD_BP_ADD: w_err = !w_dup && w_full;
        CMD_BP_RM:  w_err = !w_dup;
        4'hE, 4'hF: w_err = 1'b1;
        default:    w_err = 1'b0;
      endcase
    end else begin
      w_err = 1'b0;
    end
  end

  // Strobe decode: from the live command on acceptance, from latched state afterwards.
  always_comb begin
    w_pause  = 1'b0;
    w_resume = 1'b0;
    w_reset  = 1'b0;
    w_acc    = 4'b0000;
    w_be     = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc    = acc_of(i_cmd);
          w_be     = be_of(i_cmd, i_addr[1:0]);
          w_pause  = (i_cmd == CMD_PAUSE);
          w_resume = (i_cmd == CMD_RESUME) || ((i_cmd == CMD_STEP) && r_paused);
          w_reset  = (i_cmd == CMD_RESET);
        end else begin
          w_acc = 4'b0000;
        end
      end
      S_WAIT_PAUSE, S_STEP_PAUSE, S_BREAK_HIT: w_pause  = 1'b1;
      S_WAIT_RESUME, S_STEP_RUN:               w_resume = 1'b1;
      S_WAIT_MEM, S_WAIT_REG: begin
        w_acc = acc_of(r_cmd);
        w_be  = be_of(r_cmd, r_addr_lo);
      end
      S_MCU_RST: w_reset = 1'b1;
      default:   w_pause = 1'b0;
    endcase
  end

  assign o_pause      = w_pause;
  assign o_resume     = w_resume;
  assign o_reset      = w_reset;
  assign o_mem_rd     = w_acc[3];
  assign o_mem_wr     = w_acc[2];
  assign o_reg_rd     = w_acc[1];
  assign o_reg_wr     = w_acc[0];
  assign o_mem_be     = w_be;
  assign o_out_valid  = w_pause | w_resume | w_reset | (|w_acc);
  assign o_ctrlr_busy = (r_state != S_IDLE) || w_hit;
  assign o_mcu_paused = r_paused;
  assign o_bp_full    = w_full;
  assign o_bp_hit_idx = r_hit_idx;
  assign o_err        = w_err;

  // Control FSM; step phases ignore busy on their first cycle so the MCU
  // has a cycle to react to the newly raised strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= CMD_NONE;
      r_addr_lo  <= 2'b00;
      r_paused   <= 1'b0;
      r_step_cnt <= '0;
      r_rst_cnt  <= '0;
      r_fresh    <= 1'b0;
      r_hit_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_state   <= S_BREAK_HIT;
            r_hit_idx <= w_hit_sel;
          end else if (w_accept) begin
            r_cmd     <= i_cmd;
            r_addr_lo <= i_addr[1:0];
            case (i_cmd)
              CMD_PAUSE:  r_state <= S_WAIT_PAUSE;
              CMD_RESUME: r_state <= S_WAIT_RESUME;
              CMD_STEP: begin
                if (r_paused) begin
                  r_state    <= S_STEP_RUN;
                  r_fresh    <= 1'b0;
                  r_step_cnt <= (i_addr[STEP_W-1:0] == '0) ? STEP_W'(1) : i_addr[STEP_W-1:0];
                end else begin
                  r_state <= S_IDLE;
                end
              end
              CMD_RESET: begin
                r_paused  <= 1'b0;
                r_rst_cnt <= RC_W'(RST_CYCLES - 1);
                r_state   <= (RST_CYCLES > 1) ? S_MCU_RST : S_IDLE;
              end
              CMD_MEM_RD_B, CMD_MEM_RD_W, CMD_MEM_WR_B, CMD_MEM_WR_W: r_state <= S_WAIT_MEM;
              CMD_REG_RD, CMD_REG_WR: r_state <= S_WAIT_REG;
              default: r_state <= S_IDLE;
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT_PAUSE: begin
          if (!i_mcu_busy) begin
            r_state  <= S_IDLE;
            r_paused <= 1'b1;
          end else begin
            r_state <= S_WAIT_PAUSE;
          end
        end
        S_WAIT_RESUME: begin
          if (!i_mcu_busy) begin
            r_state  <= S_IDLE;
            r_paused <= 1'b0;
          end else begin
            r_state <= S_WAIT_RESUME;
          end
        end
        S_WAIT_MEM, S_WAIT_REG: begin
          if (!i_mcu_busy) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= r_state;
          end
        end
        S_STEP_RUN: begin
          if (r_fresh) begin
            r_fresh <= 1'b0;
          end else if (!i_mcu_busy) begin
            r_state <= S_STEP_PAUSE;
            r_fresh <= 1'b1;
          end else begin
            r_state <= S_STEP_RUN;
          end
        end
        S_STEP_PAUSE: begin
          if (r_fresh) begin
            r_fresh <= 1'b0;
          end else if (!i_mcu_busy) begin
            if (r_step_cnt == STEP_W'(1)) begin
              r_state <= S_IDLE;
            end else begin
              r_step_cnt <= r_step_cnt - STEP_W'(1);
              r_state    <= S_STEP_RUN;
              r_fresh    <= 1'b1;
            end
          end else begin
            r_state <= S_STEP_PAUSE;
          end
        end
        S_MCU_RST: begin
          if (r_rst_cnt <= RC_W'(1)) begin
            r_state <= S_IDLE;
          end else begin
            r_rst_cnt <= r_rst_cnt - RC_W'(1);
          end
        end
        S_BREAK_HIT: r_state <= S_WAIT_PAUSE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  // Breakpoint table: add fills the lowest free slot, remove clears all matches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bp_vld <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        r_bp_addr[i] <= '0;
      end
    end else if (w_add_wr) begin
      r_bp_vld[w_free_sel]  <= 1'b1;
      r_bp_addr[w_free_sel] <= i_addr;
    end else if (w_rm_wr) begin
      r_bp_vld <= r_bp_vld & ~w_addr_match;
    end else begin
      r_bp_vld <= r_bp_vld;
    end
  end

`ifdef DBG_HIT_CNT_EN
  logic [15:0] r_hit_cnt [NUM_BP];

  // Saturating per-slot hit counters, cleared when the slot is rewritten or removed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_BP; i++) begin
        r_hit_cnt[i] <= 16'd0;
      end
    end else if (w_add_wr) begin
      r_hit_cnt[w_free_sel] <= 16'd0;
    end else if (w_rm_wr) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (w_addr_match[i]) begin
          r_hit_cnt[i] <= 16'd0;
        end else begin
          r_hit_cnt[i] <= r_hit_cnt[i];
        end
      end
    end else if (w_hit && (r_hit_cnt[w_hit_sel] != 16'hFFFF)) begin
      r_hit_cnt[w_hit_sel] <= r_hit_cnt[w_hit_sel] + 16'd1;
    end else begin
      r_hit_cnt[0] <= r_hit_cnt[0];
    end
  end

  assign o_bp_hit_cnt = r_hit_cnt[r_hit_idx];
`endif

endmodule

// File: tb/tb_debug_ctrlr.sv
// Directed testbench for debug_ctrlr with hand-computed expectations.
module tb_debug_ctrlr;

  logic        clk;
  logic        rst;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic        in_valid;
  logic [31:0] pc;
  logic        mcu_busy;
  logic        pause, resume, mreset, mem_rd, mem_wr, reg_rd, reg_wr;
  logic [3:0]  mem_be;
  logic        out_valid, ctrlr_busy, mcu_paused, bp_full, err;
  logic [2:0]  bp_hit_idx;
`ifdef DBG_HIT_CNT_EN
  logic [15:0] bp_hit_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  debug_ctrlr dut (
    .i_clk(clk), .i_rst(rst), .i_cmd(cmd), .i_addr(addr), .i_in_valid(in_valid),
    .i_pc(pc), .i_mcu_busy(mcu_busy),
    .o_pause(pause), .o_resume(resume), .o_reset(mreset),
    .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_reg_rd(reg_rd), .o_reg_wr(reg_wr),
    .o_mem_be(mem_be), .o_out_valid(out_valid), .o_ctrlr_busy(ctrlr_busy),
    .o_mcu_paused(mcu_paused), .o_bp_full(bp_full), .o_bp_hit_idx(bp_hit_idx),
`ifdef DBG_HIT_CNT_EN
    .o_bp_hit_cnt(bp_hit_cnt),
`endif
    .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Sample point, away from the active edge.
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_resume();
    nxt(); cmd = 4'h2; addr = 32'h0; in_valid = 1'b1; mcu_busy = 1'b0;
    smp(); check("resume_strobe", {31'd0, resume}, 32'd1);
    nxt(); in_valid = 1'b0;
    nxt(); smp(); check("resume_unpaused", {31'd0, mcu_paused}, 32'd0);
  endtask

  int r_cyc, p_cyc, r_rise, p_rise, rc;
  logic prev_r, prev_p;

  initial begin
    rst = 1'b1; cmd = 4'h0; addr = 32'h0; in_valid = 1'b0; pc = 32'h2000; mcu_busy = 1'b0;
    #3;
    check("rst_pause", {31'd0, pause}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, ctrlr_busy}, 32'd0);
    check("rst_paused", {31'd0, mcu_paused}, 32'd0);
    check("rst_bp_full", {31'd0, bp_full}, 32'd0);
    check("rst_hit_idx", {29'd0, bp_hit_idx}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    nxt(); nxt(); rst = 1'b0;

    // PAUSE with busy high for three cycles
    nxt(); cmd = 4'h1; in_valid = 1'b1;
    smp(); check("pause_accept", {30'd0, pause, out_valid}, 32'd3);
    check("pause_accept_busy", {31'd0, ctrlr_busy}, 32'd0);
    nxt(); in_valid = 1'b0; mcu_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp(); check("pause_held", {30'd0, pause, ctrlr_busy}, 32'd3);
      nxt();
    end
    mcu_busy = 1'b0;
    smp(); check("pause_last", {30'd0, pause, mcu_paused}, 32'd2);
    nxt(); smp();
    check("pause_done", {29'd0, pause, mcu_paused, ctrlr_busy}, 32'd2);

    // MEM_WR_B to byte lane 2, lane held from the latched address
    nxt(); cmd = 4'hB; addr = 32'h12; in_valid = 1'b1;
    smp(); check("wrb_accept", {27'd0, mem_wr, mem_be}, 32'h14);
    nxt(); in_valid = 1'b0; addr = 32'h0; mcu_busy = 1'b1;
    smp(); check("wrb_hold", {26'd0, mem_rd, mem_wr, mem_be}, 32'h14);
    nxt(); mcu_busy = 1'b0;
    smp(); check("wrb_last", {27'd0, mem_wr, mem_be}, 32'h14);
    nxt(); smp(); check("wrb_done", {26'd0, mem_wr, ctrlr_busy, mem_be}, 32'h0);

    // MEM_RD_W drives all lanes
    nxt(); cmd = 4'h7; addr = 32'h13; in_valid = 1'b1;
    smp(); check("rdw_accept", {26'd0, mem_rd, mem_wr, mem_be}, 32'h2F);
    nxt(); in_valid = 1'b0;
    nxt(); smp(); check("rdw_done", {31'd0, ctrlr_busy}, 32'd0);

    // STEP 3 while paused, busy pattern 1,1,0 per phase
    nxt(); cmd = 4'h3; addr = 32'h3; in_valid = 1'b1;
    smp(); check("step_accept", {31'd0, resume}, 32'd1);
    r_cyc = 1; p_cyc = 0; r_rise = 1; p_rise = 0; prev_r = 1'b1; prev_p = 1'b0;
    nxt(); in_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      mcu_busy = (k % 3 != 2);
      smp();
      r_cyc += int'(resume); p_cyc += int'(pause);
      if (resume && !prev_r) r_rise++;
      if (pause && !prev_p) p_rise++;
      prev_r = resume; prev_p = pause;
      nxt();
    end
    smp();
    check("step_resume_cycles", r_cyc, 32'd10);
    check("step_pause_cycles", p_cyc, 32'd9);
    check("step_resume_pulses", r_rise, 32'd3);
    check("step_pause_pulses", p_rise, 32'd3);
    check("step_end", {30'd0, ctrlr_busy, mcu_paused}, 32'd1);

    // STEP with count 0 behaves as a single step
    nxt(); cmd = 4'h3; addr = 32'h100; in_valid = 1'b1;
    nxt(); in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mcu_busy = (k % 3 != 2);
      nxt();
    end
    smp(); check("step0_end", {30'd0, ctrlr_busy, mcu_paused}, 32'd1);

    // Running MCU: STEP is rejected
    do_resume();
    nxt(); cmd = 4'h3; addr = 32'h3; in_valid = 1'b1;
    smp(); check("step_run_err", {29'd0, err, resume, out_valid}, 32'd4);
    nxt(); in_valid = 1'b0;
    smp(); check("step_run_after", {30'd0, err, ctrlr_busy}, 32'd0);

    // Breakpoint at 0x100, pc 0x0FC hits slot 0; hit wins over a presented PAUSE
    nxt(); cmd = 4'h9; addr = 32'h100; in_valid = 1'b1;
    smp(); check("bp_add_err", {31'd0, err}, 32'd0);
    nxt(); cmd = 4'h1; pc = 32'h0FC;
    smp(); check("hit_cycle", {30'd0, ctrlr_busy, pause}, 32'd2);
    nxt(); in_valid = 1'b0; pc = 32'h2000;
    smp(); check("break_hit", {27'd0, pause, out_valid, bp_hit_idx}, 32'h18);
    nxt(); smp(); check("hit_wait_pause", {31'd0, pause}, 32'd1);
    nxt(); smp(); check("hit_paused", {30'd0, mcu_paused, ctrlr_busy}, 32'd2);

    // Fill the table
    for (int i = 0; i < 7; i++) begin
      nxt(); cmd = 4'h9; addr = 32'h300 + 32'(4 * i); in_valid = 1'b1;
      smp(); check("fill_not_full", {30'd0, bp_full, err}, 32'd0);
    end
    nxt(); cmd = 4'h9; addr = 32'h400;
    smp(); check("full_add_err", {30'd0, bp_full, err}, 32'd3);
    nxt(); addr = 32'h100;
    smp(); check("dup_add_noerr", {31'd0, err}, 32'd0);
    nxt(); cmd = 4'hA; addr = 32'h200;
    smp(); check("rm_nomatch_err", {31'd0, err}, 32'd1);
    nxt(); addr = 32'h300;
    smp(); check("rm_match", {31'd0, err}, 32'd0);
    nxt(); cmd = 4'h9; addr = 32'h500;
    smp(); check("readd_slot1", {30'd0, bp_full, err}, 32'd0);
    nxt(); in_valid = 1'b0;
    smp(); check("refull", {31'd0, bp_full}, 32'd1);

    // Hit on slot 1
    do_resume();
    nxt(); pc = 32'h4FC;
    smp(); check("hit1_cycle", {31'd0, ctrlr_busy}, 32'd1);
    nxt(); pc = 32'h2000;
    smp(); check("hit1_idx", {28'd0, pause, bp_hit_idx}, 32'h9);
    nxt(); nxt(); smp(); check("hit1_paused", {31'd0, mcu_paused}, 32'd1);

    // RESET pulse length
    nxt(); cmd = 4'h4; addr = 32'h0; in_valid = 1'b1;
    smp(); rc = int'(mreset);
    nxt(); in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      smp(); rc += int'(mreset);
      nxt();
    end
    smp();
    check("reset_cycles", rc, 32'd4);
    check("reset_unpaused", {30'd0, mcu_paused, ctrlr_busy}, 32'd0);
    check("reset_keeps_bp", {31'd0, bp_full}, 32'd1);

    // Async reset in the middle of a memory wait
    nxt(); cmd = 4'hB; addr = 32'h2; in_valid = 1'b1;
    smp(); check("wrb2_accept", {27'd0, mem_wr, mem_be}, 32'h14);
    nxt(); in_valid = 1'b0; mcu_busy = 1'b1;
    #1; rst = 1'b1;
    #1; check("async_rst", {25'd0, mem_wr, out_valid, ctrlr_busy, bp_full, mem_be}, 32'h0);
    #2; rst = 1'b0; mcu_busy = 1'b0; pc = 32'h0FC;
    nxt(); smp(); check("post_rst_nohit", {30'd0, ctrlr_busy, pause}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
